// File: rtl/onezero_stream_tx.sv
// onezero_stream_tx: serialises a parallel word MSB-first onto the dual-rail
// ONE/ZERO symbol strobes. Optional idle gaps go between symbols, and a
// registered RUN_HIT tracks runs of identical symbols.
// Optional feature: define ONEZERO_TX_PARITY_EN to append an even-parity symbol.
// Ports:
//   clk_i       rising-edge clock
//   reset_i     synchronous active-high reset
//   data_i      word to send, sampled on an accepted load
//   load_i      load request, accepted while ready_o=1
//   ready_o     transmitter idle and able to accept a word
//   busy_o      word in progress
//   one_o       one-cycle strobe for a logic-1 symbol
//   zero_o      one-cycle strobe for a logic-0 symbol
//   run_hit_o   current symbol extends a run of identical symbols to >= RUN_LEN
//   done_o      one-cycle pulse after the last symbol of a word
module onezero_stream_tx #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned GAP     = 0,
    parameter int unsigned RUN_LEN = 4
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             load_i,
    output logic             ready_o,
    output logic             busy_o,
    output logic             one_o,
    output logic             zero_o,
    output logic             run_hit_o,
    output logic             done_o
);

`ifdef ONEZERO_TX_PARITY_EN
    localparam int unsigned NSYM = WIDTH + 1;
`else
    localparam int unsigned NSYM = WIDTH;
`endif
    localparam int unsigned CNT_W = $clog2(NSYM);
    localparam int unsigned GAP_W = 4;
    localparam int unsigned RUN_W = 4;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NSYM - 1);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((GAP == 0) ? 0 : GAP - 1);
    localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(RUN_LEN);

    typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_GAP} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   shift_q, shift_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
    logic [RUN_W-1:0]   run_q, run_d;
    logic               sym_q, sym_d;
    logic               ready_q, ready_d;
    logic               busy_q, busy_d;
    logic               one_q, one_d;
    logic               zero_q, zero_d;
    logic               run_hit_q, run_hit_d;
    logic               done_q, done_d;
`ifdef ONEZERO_TX_PARITY_EN
    logic               parity_q, parity_d;
`endif
    logic               emit_c;
    logic               nxt_sym_c;

    // State and output registers
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            gap_cnt_q <= '0;
            run_q     <= '0;
            sym_q     <= 1'b0;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
            one_q     <= 1'b0;
            zero_q    <= 1'b0;
            run_hit_q <= 1'b0;
            done_q    <= 1'b0;
`ifdef ONEZERO_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            run_q     <= run_d;
            sym_q     <= sym_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
            one_q     <= one_d;
            zero_q    <= zero_d;
            run_hit_q <= run_hit_d;
            done_q    <= done_d;
`ifdef ONEZERO_TX_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

    // Next state; outputs are computed for the cycle after the edge
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        gap_cnt_d = gap_cnt_q;
        run_d     = run_q;
        sym_d     = sym_q;
        ready_d   = 1'b0;
        busy_d    = 1'b0;
        one_d     = 1'b0;
        zero_d    = 1'b0;
        run_hit_d = 1'b0;
        done_d    = 1'b0;
        emit_c    = 1'b0;
`ifdef ONEZERO_TX_PARITY_EN
        parity_d  = parity_q;
`endif
        // Symbol following the one currently on the wire
        nxt_sym_c = shift_q[WIDTH-2];
`ifdef ONEZERO_TX_PARITY_EN
        if (bit_cnt_q == CNT_W'(WIDTH - 1)) begin
            nxt_sym_c = parity_q;
        end
`endif

        unique case (state_q)
            ST_IDLE: begin
                ready_d = 1'b1;
                if (load_i) begin
                    // First symbol goes out in the cycle right after acceptance
                    state_d   = ST_SEND;
                    shift_d   = data_i;
                    bit_cnt_d = '0;
                    run_d     = RUN_W'(1);
                    sym_d     = data_i[WIDTH-1];
                    one_d     = data_i[WIDTH-1];
                    zero_d    = ~data_i[WIDTH-1];
                    ready_d   = 1'b0;
                    busy_d    = 1'b1;
`ifdef ONEZERO_TX_PARITY_EN
                    parity_d  = ^data_i;
`endif
                end
            end
            ST_SEND: begin
                if (bit_cnt_q == LAST_IDX) begin
                    state_d = ST_IDLE;
                    ready_d = 1'b1;
                    done_d  = 1'b1;
                end else if (GAP > 0) begin
                    state_d   = ST_GAP;
                    gap_cnt_d = GAP_LOAD;
                    busy_d    = 1'b1;
                end else begin
                    emit_c = 1'b1;
                end
            end
            ST_GAP: begin
                busy_d = 1'b1;
                if (gap_cnt_q == '0) begin
                    emit_c = 1'b1;
                end else begin
                    gap_cnt_d = gap_cnt_q - GAP_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                ready_d = 1'b1;
            end
        endcase

        // Advance to the next symbol; gaps leave the run counter untouched
        if (emit_c) begin
            state_d   = ST_SEND;
            busy_d    = 1'b1;
            shift_d   = {shift_q[WIDTH-2:0], 1'b0};
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
            sym_d     = nxt_sym_c;
            one_d     = nxt_sym_c;
            zero_d    = ~nxt_sym_c;
            if (nxt_sym_c != sym_q) begin
                run_d = RUN_W'(1);
            end else if (run_q < RUN_MAX) begin
                run_d = run_q + RUN_W'(1);
            end
            run_hit_d = (run_d >= RUN_MAX);
        end
    end

    assign ready_o   = ready_q;
    assign busy_o    = busy_q;
    assign one_o     = one_q;
    assign zero_o    = zero_q;
    assign run_hit_o = run_hit_q;
    assign done_o    = done_q;

endmodule

// File: tb/tb_onezero_stream_tx.sv
// tb_onezero_stream_tx: bench for onezero_stream_tx with two instances,
// GAP=0 (dut_a) and GAP=2 (dut_b), checked cycle by cycle against a
// word-level reference model of the symbol timeline.
module tb_onezero_stream_tx;

    localparam int RUN_LEN = 4;

    logic       clk;
    logic       rst;
    logic       ld_a, ld_b;
    logic [7:0] dat_a, dat_b;
    logic       rdy_a, bsy_a, one_a, zro_a, hit_a, don_a;
    logic       rdy_b, bsy_b, one_b, zro_b, hit_b, don_b;

    int n_checks = 0;
    int n_fail   = 0;

    onezero_stream_tx #(.WIDTH(8), .GAP(0), .RUN_LEN(RUN_LEN)) dut_a (
        .clk_i(clk), .reset_i(rst), .data_i(dat_a), .load_i(ld_a),
        .ready_o(rdy_a), .busy_o(bsy_a), .one_o(one_a), .zero_o(zro_a),
        .run_hit_o(hit_a), .done_o(don_a)
    );

    onezero_stream_tx #(.WIDTH(8), .GAP(2), .RUN_LEN(RUN_LEN)) dut_b (
        .clk_i(clk), .reset_i(rst), .data_i(dat_b), .load_i(ld_b),
        .ready_o(rdy_b), .busy_o(bsy_b), .one_o(one_b), .zero_o(zro_b),
        .run_hit_o(hit_b), .done_o(don_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int gap_of(input bit sel);
        return sel ? 2 : 0;
    endfunction

    function automatic int nsym();
`ifdef ONEZERO_TX_PARITY_EN
        return 9;
`else
        return 8;
`endif
    endfunction

    // Cycle of the last symbol, counted from cycle 1 after the accepting edge
    function automatic int last_cycle(input bit sel);
        return 1 + (nsym() - 1) * (gap_of(sel) + 1);
    endfunction

    // Expected {ready,busy,one,zero,run_hit,done} in cycle c of a word
    function automatic logic [5:0] exp_vec(input logic [7:0] d, input bit sel, input int c);
        logic       syms [9];
        int         g, last, k, r;
        logic [5:0] v;
        g = gap_of(sel);
        for (int i = 0; i < 8; i++) syms[i] = d[7-i];
        syms[8] = ^d;
        last = last_cycle(sel);
        v = '0;
        if (c > last) begin
            v[5] = 1'b1;
            v[0] = (c == last + 1);
        end else begin
            v[4] = 1'b1;
            if ((c - 1) % (g + 1) == 0) begin
                k = (c - 1) / (g + 1);
                r = 1;
                for (int j = k - 1; j >= 0; j--) begin
                    if (syms[j] != syms[k]) break;
                    r++;
                end
                v[3] = syms[k];
                v[2] = !syms[k];
                v[1] = (r >= RUN_LEN);
            end
        end
        return v;
    endfunction

    function automatic logic [5:0] obs(input bit sel);
        return sel ? {rdy_b, bsy_b, one_b, zro_b, hit_b, don_b}
                   : {rdy_a, bsy_a, one_a, zro_a, hit_a, don_a};
    endfunction

    task automatic drive(input bit sel, input logic l, input logic [7:0] d);
        if (sel) begin ld_b = l; dat_b = d; end
        else     begin ld_a = l; dat_a = d; end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a load to an idle DUT; returns in cycle 1 of the word
    task automatic load_word(input bit sel, input logic [7:0] d);
        drive(sel, 1'b1, d);
        step();
        drive(sel, 1'b0, 8'($urandom));
    endtask

    // Check every cycle of a word in flight. With chain set, LOAD stays high
    // and the word nd is accepted in the DONE cycle; otherwise random LOAD
    // pulses hit the busy DUT and one trailing idle cycle is also checked.
    task automatic trace_word(input string name, input bit sel, input logic [7:0] d,
                              input bit chain, input logic [7:0] nd);
        int         done_c, end_c;
        logic [5:0] e, o;
        done_c = last_cycle(sel) + 1;
        end_c  = chain ? done_c : done_c + 1;
        for (int c = 1; c <= end_c; c++) begin
            e = exp_vec(d, sel, c);
            o = obs(sel);
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL %s data=%h cyc %0d: got rdy/bsy/one/zro/hit/done=%b expected %b",
                         name, d, c, o, e);
            end
            if (chain)
                drive(sel, 1'b1, (c == done_c) ? nd : 8'($urandom));
            else
                drive(sel, (c < done_c) ? 1'($urandom) : 1'b0, 8'($urandom));
            step();
        end
        drive(sel, 1'b0, 8'($urandom));
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        for (int s = 0; s < 2; s++) begin
            n_checks++;
            if (obs(s[0]) !== 6'b100000) begin
                n_fail++;
                $display("FAIL reset_state dut%0d: got %b expected %b", s, obs(s[0]), 6'b100000);
            end
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_patterns();
        load_word(1'b0, 8'hF0);
        trace_word("pattern_f0", 1'b0, 8'hF0, 1'b0, 8'h00);
        load_word(1'b0, 8'hA5);
        trace_word("pattern_a5", 1'b0, 8'hA5, 1'b0, 8'h00);
        load_word(1'b1, 8'hFF);
        trace_word("gap2_ff", 1'b1, 8'hFF, 1'b0, 8'h00);
        load_word(1'b1, 8'h36);
        trace_word("gap2_36", 1'b1, 8'h36, 1'b0, 8'h00);
    endtask

    task automatic test_back_to_back();
        load_word(1'b0, 8'h0F);
        drive(1'b0, 1'b1, 8'h0F);
        trace_word("b2b_word1", 1'b0, 8'h0F, 1'b1, 8'hFF);
        trace_word("b2b_word2", 1'b0, 8'hFF, 1'b0, 8'h00);
        load_word(1'b1, 8'hC3);
        drive(1'b1, 1'b1, 8'hC3);
        trace_word("b2b_gap_word1", 1'b1, 8'hC3, 1'b1, 8'h3C);
        trace_word("b2b_gap_word2", 1'b1, 8'h3C, 1'b0, 8'h00);
    endtask

    task automatic test_reset_mid_word();
        logic [5:0] o;
        load_word(1'b0, 8'hFF);
        for (int c = 1; c <= 3; c++) begin
            o = obs(1'b0);
            n_checks++;
            if (o !== exp_vec(8'hFF, 1'b0, c)) begin
                n_fail++;
                $display("FAIL abort_prefix cyc %0d: got %b expected %b", c, o, exp_vec(8'hFF, 1'b0, c));
            end
            if (c == 3) begin
                rst = 1'b1;
                ld_a = 1'b1;
            end
            step();
        end
        rst  = 1'b0;
        ld_a = 1'b0;
        for (int c = 4; c <= 6; c++) begin
            o = obs(1'b0);
            n_checks++;
            if (o !== 6'b100000) begin
                n_fail++;
                $display("FAIL abort_idle cyc %0d: got %b expected %b", c, o, 6'b100000);
            end
            step();
        end
        load_word(1'b0, 8'h00);
        trace_word("after_abort_00", 1'b0, 8'h00, 1'b0, 8'h00);
    endtask

    task automatic test_random();
        logic [7:0] d;
        for (int i = 0; i < 12; i++) begin
            d = 8'($urandom);
            load_word(i[0], d);
            trace_word("random", i[0], d, 1'b0, 8'h00);
        end
    endtask

    initial begin
        rst   = 1'b1;
        ld_a  = 1'b0;
        ld_b  = 1'b0;
        dat_a = 8'h00;
        dat_b = 8'h00;
        test_reset();
        test_patterns();
        test_back_to_back();
        test_reset_mid_word();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
